// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: round-robin two-requester scheduler for the shared 4-bit two-lane ALU
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/sel  op request from requester N (ready is combinational)
//   rspN_valid/ready/data     result {carry, out[3:0]} back to requester N
//   alu_a/b/sel/active        ALU drive, active 2'b00 = enabled, 2'b11 = idle
//   alu_out, alu_carry        ALU result
//   busy                      sequencer not idle
//   op_cnt0/op_cnt1           completed response handshakes per requester (ALU_OPCOUNT_EN only)
module alu_op_sequencer #(
   parameter int ALU_LAT = 1
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic [1:0] req0_sel,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic [1:0] req1_sel,
   output logic       rsp0_valid,
   input  logic       rsp0_ready,
   output logic [4:0] rsp0_data,
   output logic       rsp1_valid,
   input  logic       rsp1_ready,
   output logic [4:0] rsp1_data,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_sel,
   output logic [1:0] alu_active,
   input  logic [3:0] alu_out,
   input  logic       alu_carry,
`ifdef ALU_OPCOUNT_EN
   output logic [7:0] op_cnt0,
   output logic [7:0] op_cnt1,
`endif
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t     state;
   logic       rr_ptr;
   logic       owner;
   logic [3:0] lat_cnt;
   // rr_ptr wins a tie; a lone valid wins regardless; gated by reset so nothing is granted while held
   assign req0_ready = ~wb_rst_i & (state == IDLE) & req0_valid & (~rr_ptr | ~req1_valid);
   assign req1_ready = ~wb_rst_i & (state == IDLE) & req1_valid & (rr_ptr | ~req0_valid);
   assign busy = state != IDLE;
   // ALU drive is loaded on the accept edge so it is already valid throughout ISSUE
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         rr_ptr     <= 1'b0;
         owner      <= 1'b0;
         lat_cnt    <= 4'd0;
         alu_a      <= 4'd0;
         alu_b      <= 4'd0;
         alu_sel    <= 2'd0;
         alu_active <= 2'b11;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= 5'd0;
         rsp1_data  <= 5'd0;
`ifdef ALU_OPCOUNT_EN
         op_cnt0    <= 8'd0;
         op_cnt1    <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE: if (req0_ready | req1_ready) begin
               owner      <= req1_ready;
               alu_a      <= req1_ready ? req1_a : req0_a;
               alu_b      <= req1_ready ? req1_b : req0_b;
               alu_sel    <= req1_ready ? req1_sel : req0_sel;
               alu_active <= 2'b00;
               state      <= ISSUE;
            end
            ISSUE: begin
               lat_cnt <= 4'(ALU_LAT - 1);
               state   <= WAIT;
            end
            WAIT: if (lat_cnt == 4'd0) begin
               rsp0_data  <= owner ? rsp0_data : {alu_carry, alu_out};
               rsp1_data  <= owner ? {alu_carry, alu_out} : rsp1_data;
               rsp0_valid <= ~owner;
               rsp1_valid <= owner;
               alu_a      <= 4'd0;
               alu_b      <= 4'd0;
               alu_sel    <= 2'd0;
               alu_active <= 2'b11;
               state      <= RESP;
            end else begin
               lat_cnt <= lat_cnt - 4'd1;
            end
            RESP: if (owner ? rsp1_ready : rsp0_ready) begin
               rsp0_valid <= 1'b0;
               rsp1_valid <= 1'b0;
               rr_ptr     <= ~owner;
               state      <= IDLE;
`ifdef ALU_OPCOUNT_EN
               op_cnt0    <= owner ? op_cnt0 : op_cnt0 + 8'd1;
               op_cnt1    <= owner ? op_cnt1 + 8'd1 : op_cnt1;
`endif
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of alu_op_sequencer at ALU_LAT=1 (u[0]) and ALU_LAT=4 (u[1])
module tb_alu_op_sequencer;
   logic       clk, rst;
   logic       r0v [2], r0r [2], r1v [2], r1r [2];
   logic [3:0] r0a [2], r0b [2], r1a [2], r1b [2];
   logic [1:0] r0s [2], r1s [2];
   logic       s0v [2], s0r [2], s1v [2], s1r [2];
   logic [4:0] s0d [2], s1d [2];
   logic [3:0] aa [2], ab [2], ao [2];
   logic [1:0] asel [2], aact [2];
   logic       ac [2], bsy [2];
`ifdef ALU_OPCOUNT_EN
   logic [7:0] c0 [2], c1 [2];
`endif
   int checks = 0;
   int fails = 0;
   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      case (s)
         2'd0:    return {1'b0, a} + {1'b0, b};
         2'd1:    return {1'b0, a} - {1'b0, b};
         2'd2:    return {1'b0, a ^ b};
         default: return {1'b0, a & b};
      endcase
   endfunction
   for (genvar i = 0; i < 2; i++) begin : u
      localparam int LAT = (i == 0) ? 1 : 4;
      logic [4:0] pipe [LAT];
      alu_op_sequencer #(.ALU_LAT(LAT)) dut (
         .wb_clk_i(clk), .wb_rst_i(rst),
         .req0_valid(r0v[i]), .req0_ready(r0r[i]), .req0_a(r0a[i]), .req0_b(r0b[i]), .req0_sel(r0s[i]),
         .req1_valid(r1v[i]), .req1_ready(r1r[i]), .req1_a(r1a[i]), .req1_b(r1b[i]), .req1_sel(r1s[i]),
         .rsp0_valid(s0v[i]), .rsp0_ready(s0r[i]), .rsp0_data(s0d[i]),
         .rsp1_valid(s1v[i]), .rsp1_ready(s1r[i]), .rsp1_data(s1d[i]),
         .alu_a(aa[i]), .alu_b(ab[i]), .alu_sel(asel[i]), .alu_active(aact[i]),
         .alu_out(ao[i]), .alu_carry(ac[i]),
`ifdef ALU_OPCOUNT_EN
         .op_cnt0(c0[i]), .op_cnt1(c1[i]),
`endif
         .busy(bsy[i])
      );
      // ALU model: result appears LAT clocks after operands are applied
      always_ff @(posedge clk) begin
         pipe[0] <= (aact[i] == 2'b00) ? alu_f(aa[i], ab[i], asel[i]) : 5'd0;
         for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      end
      assign {ac[i], ao[i]} = pipe[LAT-1];
   end
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end
   initial begin
      int n, cyc, lastc, both, idle, bad, got0, act, idx, hs;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         r0v[i] = 0; r0a[i] = 0; r0b[i] = 0; r0s[i] = 0;
         r1v[i] = 0; r1a[i] = 0; r1b[i] = 0; r1s[i] = 0;
         s0r[i] = 0; s1r[i] = 0;
      end
      do_reset();
      chk("rst_act", aact[0], 2'b11);
      chk("rst_busy", bsy[0], 0);
      chk("rst_alu_a", aa[0], 0);
      chk("rst_rsp0_v", s0v[0], 0);
      chk("rst_rsp0_d", s0d[0], 0);
      // single op, ALU_LAT=1: 9+8 = 0x11
      r0v[0] = 1; r0a[0] = 4'h9; r0b[0] = 4'h8; r0s[0] = 2'b00;
      #1;
      chk("t1_rdy0", r0r[0], 1);
      chk("t1_rdy1", r1r[0], 0);
      tick();
      r0v[0] = 0; r0a[0] = 0; r0b[0] = 0;
      #1;
      chk("t1_rdy_drop", r0r[0], 0);
      chk("t1_issue_act", aact[0], 2'b00);
      chk("t1_issue_a", aa[0], 4'h9);
      chk("t1_issue_b", ab[0], 4'h8);
      tick();
      chk("t1_wait_act", aact[0], 2'b00);
      chk("t1_wait_v", s0v[0], 0);
      tick();
      chk("t1_resp_act", aact[0], 2'b11);
      chk("t1_rsp_v", s0v[0], 1);
      chk("t1_rsp_d", s0d[0], 5'h11);
      s0r[0] = 1;
      tick();
      s0r[0] = 0;
      chk("t1_done_v", s0v[0], 0);
      chk("t1_idle", bsy[0], 0);
      // continuous contention: req0 3+4=0x07, req1 5^3=0x06
      do_reset();
      r0v[0] = 1; r0a[0] = 4'h3; r0b[0] = 4'h4; r0s[0] = 2'd0;
      r1v[0] = 1; r1a[0] = 4'h5; r1b[0] = 4'h3; r1s[0] = 2'd2;
      s0r[0] = 1; s1r[0] = 1;
      #1;
      n = 0; cyc = 0; lastc = 0; both = 0; idle = 0;
      while (n < 6 && cyc < 80) begin
         if (r0r[0] & r1r[0]) both++;
         if (s0v[0]) chk("t2_d0", s0d[0], 5'h07);
         if (s1v[0]) chk("t2_d1", s1d[0], 5'h06);
         if (n > 0 && !bsy[0]) idle++;
         if (r0r[0] | r1r[0]) begin
            chk("t2_grant", r1r[0], n % 2);
            if (n > 0) chk("t2_gap", cyc - lastc, 4);
            lastc = cyc;
            n++;
         end
         if (n < 6) begin
            tick();
            cyc++;
         end
      end
      chk("t2_ops", n, 6);
      chk("t2_both", both, 0);
      chk("t2_idle", idle, 5);
      tick();
      r0v[0] = 0; r1v[0] = 0;
      repeat (4) tick();
      chk("t2_drain", bsy[0], 0);
      // response back-pressure on req1 (0xA & 0x3 = 0x02) while req0 waits
      s0r[0] = 0; s1r[0] = 0;
      r1v[0] = 1; r1a[0] = 4'hA; r1b[0] = 4'h3; r1s[0] = 2'd3;
      #1;
      chk("t3_rdy1", r1r[0], 1);
      tick();
      r1v[0] = 0;
      r0v[0] = 1; r0a[0] = 4'h1; r0b[0] = 4'h1; r0s[0] = 2'd0;
      for (int c = 0; c < 10 && !s1v[0]; c++) tick();
      chk("t3_rsp_v", s1v[0], 1);
      bad = 0;
      repeat (10) begin
         if (s1v[0] !== 1'b1 || s1d[0] !== 5'h02 || r0r[0] !== 1'b0 || bsy[0] !== 1'b1) bad++;
         tick();
      end
      chk("t3_hold", bad, 0);
      s1r[0] = 1;
      #1;
      chk("t3_rdy0_before", r0r[0], 0);
      tick();
      s1r[0] = 0;
      chk("t3_rdy0_after", r0r[0], 1);
      chk("t3_v1_off", s1v[0], 0);
      chk("t3_d1_hold", s1d[0], 5'h02);
      tick();
      r0v[0] = 0; s0r[0] = 1;
      tick();
      tick();
      chk("t3_rsp0_v", s0v[0], 1);
      chk("t3_rsp0_d", s0d[0], 5'h02);
      tick();
      // ALU_LAT=4: 0xF - 0x1 = 0x0E
      r1v[1] = 1; r1a[1] = 4'hF; r1b[1] = 4'h1; r1s[1] = 2'd1;
      #1;
      chk("t4_rdy1", r1r[1], 1);
      tick();
      r1v[1] = 0;
      act = 0; idx = 0;
      for (int c = 1; c <= 20; c++) begin
         if (aact[1] == 2'b00) act++;
         if (s1v[1]) begin
            idx = c;
            break;
         end
         tick();
      end
      chk("t4_act", act, 5);
      chk("t4_lat", idx, 6);
      chk("t4_d", s1d[1], 5'h0E);
      s1r[1] = 1;
      tick();
      s1r[1] = 0;
      chk("t4_idle", bsy[1], 0);
      // reset in WAIT with rr_ptr=1 on u[0]
      s0r[0] = 0;
      r1v[0] = 1; r1a[0] = 4'h7; r1b[0] = 4'h7; r1s[0] = 2'd0;
      #1;
      chk("t5_rdy1", r1r[0], 1);
      tick();
      r1v[0] = 0;
      tick();
      chk("t5_wait", aact[0], 2'b00);
      rst = 1;
      r0v[0] = 1; r0a[0] = 4'h2; r0b[0] = 4'h2; r0s[0] = 2'd0;
      r1v[0] = 1;
      #1;
      chk("t5_act", aact[0], 2'b11);
      chk("t5_busy", bsy[0], 0);
      chk("t5_alu_a", aa[0], 0);
      chk("t5_alu_sel", asel[0], 0);
      chk("t5_d0", s0d[0], 0);
      chk("t5_d1", s1d[0], 0);
      chk("t5_v1", s1v[0], 0);
      chk("t5_rdy0_rst", r0r[0], 0);
      chk("t5_rdy1_rst", r1r[0], 0);
      tick();
      tick();
      rst = 0;
      #1;
      chk("t5_grant0", r0r[0], 1);
      chk("t5_grant1", r1r[0], 0);
      tick();
      r0v[0] = 0; r1v[0] = 0; s0r[0] = 1; s1r[0] = 0;
      bad = 0; got0 = 0;
      repeat (6) begin
         if (s1v[0]) bad++;
         if (s0v[0]) begin
            got0++;
            chk("t5_rsp0_d", s0d[0], 5'h04);
         end
         tick();
      end
      chk("t5_no_rsp1", bad, 0);
      chk("t5_rsp0_cnt", got0, 1);
`ifdef ALU_OPCOUNT_EN
      // 257 req0 handshakes wrap op_cnt0 to 1
      do_reset();
      r0v[0] = 1; r0a[0] = 4'h1; r0b[0] = 4'h2; r0s[0] = 2'd0; s0r[0] = 1;
      hs = 0;
      for (int c = 0; c < 3000 && hs < 257; c++) begin
         if (s0v[0]) begin
            hs++;
            if (hs == 257) r0v[0] = 0;
         end
         tick();
      end
      tick();
      chk("t6_hs", hs, 257);
      chk("t6_cnt0", c0[0], 8'd1);
      chk("t6_cnt1", c1[0], 8'd0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
